// File: rtl/upower_ctrl_pkg.sv
// Shared constants and types for the uPOWER multi-cycle control FSM:
// opcode/XO values, ALUOp encodings, state encodings and instruction classes.
package upower_ctrl_pkg;

    localparam logic [5:0] OP_LD    = 6'd58;
    localparam logic [5:0] OP_STD   = 6'd62;
    localparam logic [5:0] OP_BC    = 6'd19;
    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd24;
    localparam logic [5:0] OP_ANDI  = 6'd28;
    localparam logic [5:0] OP_XFORM = 6'd31;

    localparam logic [8:0] XO_AND   = 9'd28;
    localparam logic [8:0] XO_SUBF  = 9'd40;
    localparam logic [8:0] XO_ADD   = 9'd266;
    localparam logic [8:0] XO_OR    = 9'd444;
    localparam logic [8:0] XO_NAND  = 9'd476;

    typedef enum logic [1:0] {
        ALU_ADDR = 2'b00,
        ALU_BR   = 2'b01,
        ALU_DEC  = 2'b10
    } aluop_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_ALU = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_TRAP   = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CLS_MEM_LD = 3'd0,
        CLS_MEM_ST = 3'd1,
        CLS_BR     = 3'd2,
        CLS_IMM    = 3'd3,
        CLS_XR     = 3'd4,
        CLS_BAD    = 3'd5
    } iclass_e;

    // States that hold mem_req high and wait for mem_ack.
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/upower_multicycle_control_if.sv
// Instruction/data memory req/ack handshake between the control FSM and memory.
interface upower_multicycle_control_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_we, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_we, output mem_ack, output mem_rdata);
endinterface

// File: rtl/upower_instr_classifier.sv
// Combinational instruction classifier: opcode/XO fields -> instruction class.
module upower_instr_classifier
    import upower_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [8:0] xo,
    output iclass_e    iclass
);

    always_comb begin
        iclass = CLS_BAD;
        case (opcode)
            OP_LD:                    iclass = CLS_MEM_LD;
            OP_STD:                   iclass = CLS_MEM_ST;
            OP_BC:                    iclass = CLS_BR;
            OP_ADDI, OP_ORI, OP_ANDI: iclass = CLS_IMM;
            OP_XFORM: begin
                if (xo inside {XO_AND, XO_SUBF, XO_ADD, XO_OR, XO_NAND})
                    iclass = CLS_XR;
            end
            default: iclass = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/upower_multicycle_control.sv
// Multi-cycle main control FSM for the uPOWER datapath (fetch, decode, execute, writeback).
// Build option UPOWER_ILLEGAL_TRAP_EN: unsupported instructions lock the FSM in TRAP instead of acting as NOP.
module upower_multicycle_control
    import upower_ctrl_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    upower_multicycle_control_if.master  mem,
    output logic [1:0]                   ALUOp,
    output logic [5:0]                   OpCode,
    output logic [8:0]                   XO,
    output logic                         ir_write,
    output logic                         pc_write,
    output logic                         pc_write_cond,
    output logic                         reg_write,
    output logic                         mem_to_reg,
    output logic                         alu_src_imm,
    output logic                         mem_timeout,
    output logic                         illegal,
    output logic [3:0]                   state_o
);

    localparam bit TMO_EN = (ACK_TIMEOUT > 0);
    localparam int CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_e               state, state_nxt;
    logic [INSTR_W-1:0]   ir;
    logic [CNT_W-1:0]     wait_cnt;
    iclass_e              iclass;
    aluop_e               aluop;
    logic                 tmo_hit;
    logic                 unused_ir_bits;

    assign OpCode         = ir[31:26];
    assign XO             = ir[9:1];
    assign ALUOp          = aluop;
    assign state_o        = state;
    assign unused_ir_bits = ^{ir[25:10], ir[0]};

    upower_instr_classifier u_classifier (
        .opcode (ir[31:26]),
        .xo     (ir[9:1]),
        .iclass (iclass)
    );

    // Down-counter reaches zero on the last allowed unacked cycle; an ack in that cycle still wins.
    assign tmo_hit = TMO_EN && is_mem_state(state) && !mem.mem_ack && (wait_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_timeout <= tmo_hit;
            if (state == S_FETCH && mem.mem_ack)
                ir <= mem.mem_rdata;
            if (state_nxt != state)
                wait_cnt <= CNT_LOAD;
            else if (wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        aluop         = ALU_ADDR;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_imm   = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DECODE: begin
                case (iclass)
                    CLS_MEM_LD, CLS_MEM_ST: state_nxt = S_ADDR;
                    CLS_BR:                 state_nxt = S_BRANCH;
                    CLS_IMM:                state_nxt = S_EXEC_I;
                    CLS_XR:                 state_nxt = S_EXEC_R;
`ifdef UPOWER_ILLEGAL_TRAP_EN
                    default:                state_nxt = S_TRAP;
`else
                    default:                state_nxt = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                aluop     = ALU_DEC;
                state_nxt = S_WB_ALU;
            end
            S_EXEC_I: begin
                aluop       = ALU_DEC;
                alu_src_imm = 1'b1;
                state_nxt   = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDR: begin
                alu_src_imm = 1'b1;
                state_nxt   = (iclass == CLS_MEM_ST) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack)  state_nxt = S_WB_MEM;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_MEM_WR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                if (mem.mem_ack)  state_nxt = S_FETCH;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
                aluop         = ALU_BR;
                pc_write_cond = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef UPOWER_ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_upower_multicycle_control.sv
// Self-checking bench: a per-cycle expected trace is built from the instruction-level rules and replayed against the DUT.
module tb_upower_multicycle_control;
    import upower_ctrl_pkg::*;

    localparam int T = 4;
    localparam int K_LD = 0, K_ST = 1, K_BR = 2, K_IMM = 3, K_XR = 4, K_BAD = 5;
    localparam logic [31:0] W_ADD = 32'h7C611214;
    localparam logic [31:0] W_LD  = 32'hE8610008;
    localparam logic [31:0] W_STD = 32'hF8610008;
    localparam logic [31:0] W_BC  = 32'h4C000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ALUOp;
    logic [5:0] OpCode;
    logic [8:0] XO;
    logic       ir_write, pc_write, pc_write_cond, reg_write, mem_to_reg, alu_src_imm;
    logic       mem_timeout, illegal;
    logic [3:0] state_o;

    int n_chk  = 0;
    int n_fail = 0;

    upower_multicycle_control_if mif ();

    upower_multicycle_control #(.INSTR_W(32), .ACK_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem           (mif),
        .ALUOp         (ALUOp),
        .OpCode        (OpCode),
        .XO            (XO),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_imm   (alu_src_imm),
        .mem_timeout   (mem_timeout),
        .illegal       (illegal),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic [10:0] exp;
        logic [31:0] ir;
        logic        ill;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_ir  = '0;
    logic        m_ill = 1'b0;

    // {req, we, aluop[1:0], ir_write, pc_write, pc_write_cond, reg_write, mem_to_reg, alu_src_imm, mem_timeout}
    function automatic logic [10:0] mk(bit req, bit we, bit [1:0] aop, bit irw, bit pcw,
                                       bit pcc, bit rw, bit m2r, bit imm, bit tmo);
        return {req, we, aop, irw, pcw, pcc, rw, m2r, imm, tmo};
    endfunction

    function automatic void push(logic ack, logic [31:0] rd, logic [10:0] e);
        cyc_t c;
        c.ack = ack; c.rdata = rd; c.exp = e; c.ir = m_ir; c.ill = m_ill;
        q.push_back(c);
    endfunction

    // Cycle where nobody requests memory: ack is random and must be ignored.
    function automatic void idle(logic [10:0] e);
        push(1'($urandom_range(0, 1)), $urandom, e);
    endfunction

    // Requesting phase: ack after d waits; d >= T aborts with a timeout pulse in IDLE.
    function automatic bit mem_phase(bit we, int d, logic [31:0] rd, bit fetch);
        for (int i = 0; i < T; i++) begin
            if (i == d) begin
                push(1'b1, rd, mk(1, we, 2'b00, fetch, fetch, 0, 0, 0, 0, 0));
                return 1'b1;
            end
            push(1'b0, $urandom, mk(1, we, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        end
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
        return 1'b0;
    endfunction

    function automatic int kind(logic [31:0] w);
        int op, xo;
        op = int'(w[31:26]);
        xo = int'(w[9:1]);
        if (op == 58) return K_LD;
        if (op == 62) return K_ST;
        if (op == 19) return K_BR;
        if (op == 14 || op == 24 || op == 28) return K_IMM;
        if (op == 31 && (xo == 28 || xo == 40 || xo == 266 || xo == 444 || xo == 476)) return K_XR;
        return K_BAD;
    endfunction

    function automatic void instr(logic [31:0] w, int df, int dm);
        if (!mem_phase(1'b0, df, w, 1'b1)) return;
        m_ir = w;
        idle('0);
        case (kind(w))
            K_LD: begin
                idle(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
                if (mem_phase(1'b0, dm, $urandom, 1'b0))
                    idle(mk(0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0));
            end
            K_ST: begin
                idle(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
                void'(mem_phase(1'b1, dm, $urandom, 1'b0));
            end
            K_BR:  idle(mk(0, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0));
            K_IMM: begin
                idle(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 1, 0));
                idle(mk(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0));
            end
            K_XR: begin
                idle(mk(0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0));
                idle(mk(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0));
            end
            default: begin
                if (m_ill == 1'b0) begin
`ifdef UPOWER_ILLEGAL_TRAP_EN
                    m_ill = 1'b1;
`endif
                end
            end
        endcase
    endfunction

    function automatic logic [10:0] obs();
        return {mif.mem_req, mif.mem_we, ALUOp, ir_write, pc_write, pc_write_cond,
                reg_write, mem_to_reg, alu_src_imm, mem_timeout};
    endfunction

    // Replay the expected trace one cycle per entry, starting and ending on a falling edge.
    task automatic run_q(input string tag);
        cyc_t c;
        int   step;
        step = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            mif.mem_ack   = c.ack;
            mif.mem_rdata = c.rdata;
            #1;
            n_chk++;
            if (obs() !== c.exp) begin
                n_fail++;
                $display("FAIL %s step %0d strobes: got %b want %b", tag, step, obs(), c.exp);
            end
            n_chk++;
            if ({OpCode, XO} !== {c.ir[31:26], c.ir[9:1]}) begin
                n_fail++;
                $display("FAIL %s step %0d opcode/xo: got %0d/%0d want %0d/%0d",
                         tag, step, OpCode, XO, c.ir[31:26], c.ir[9:1]);
            end
            n_chk++;
            if (illegal !== c.ill) begin
                n_fail++;
                $display("FAIL %s step %0d illegal: got %b want %b", tag, step, illegal, c.ill);
            end
            if (c.exp[0]) begin
                n_chk++;
                if (state_o !== 4'(S_IDLE)) begin
                    n_fail++;
                    $display("FAIL %s step %0d state after timeout: got %0d want %0d",
                             tag, step, state_o, 4'(S_IDLE));
                end
            end
            step++;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs() !== 11'b0) begin
            n_fail++;
            $display("FAIL reset strobes: got %b want 0", obs());
        end
        n_chk++;
        if ({OpCode, XO} !== 15'b0) begin
            n_fail++;
            $display("FAIL reset opcode/xo: got %0d/%0d want 0/0", OpCode, XO);
        end
        n_chk++;
        if (state_o !== 4'(S_IDLE) || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset state/illegal: got %0d/%b want %0d/0", state_o, illegal, 4'(S_IDLE));
        end
        rst   = 1'b0;
        m_ir  = '0;
        m_ill = 1'b0;
        idle('0);
    endtask

    task automatic test_directed();
        instr(W_ADD, 0, 0);
        instr(W_LD, 0, 3);
        instr(W_STD, 0, 0);
        instr(W_BC, 0, 0);
        instr(W_STD, 2, 3);
        instr(W_BC, 1, 0);
`ifndef UPOWER_ILLEGAL_TRAP_EN
        instr(32'h0000_0000, 0, 0);
        instr(W_ADD, 3, 0);
`endif
        run_q("directed");
    endtask

    task automatic test_timeout();
        instr(W_ADD, T, 0);
        instr(W_ADD, 0, 0);
        instr(W_LD, 0, T);
        instr(W_STD, 0, T);
        instr(W_LD, T - 1, T - 1);
        run_q("timeout");
    endtask

    task automatic test_random();
        logic [31:0] w;
        int xos[5] = '{28, 40, 266, 444, 476};
        int k, r, df, dm;
        for (int n = 0; n < 60; n++) begin
`ifdef UPOWER_ILLEGAL_TRAP_EN
            k = $urandom_range(0, 4);
`else
            k = $urandom_range(0, 5);
`endif
            w = $urandom;
            r = $urandom_range(0, 4);
            case (k)
                0: w[31:26] = 6'd58;
                1: w[31:26] = 6'd62;
                2: w[31:26] = 6'd19;
                3: w[31:26] = (r < 2) ? 6'd14 : ((r < 4) ? 6'd24 : 6'd28);
                4: begin w[31:26] = 6'd31; w[9:1] = 9'(xos[r]); end
                default: begin
                    do begin
                        w = $urandom;
                        if (r < 3) w[31:26] = 6'd31;
                    end while (kind(w) != K_BAD);
                end
            endcase
            df = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
            dm = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
            instr(w, df, dm);
        end
        run_q("random");
    endtask

    task automatic test_reset_mid_access();
        void'(mem_phase(1'b0, 0, W_LD, 1'b1));
        m_ir = W_LD;
        idle('0);
        idle(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        run_q("rst_mid_pre");
        mif.mem_ack = 1'b0;
        #1;
        n_chk++;
        if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid waiting req/we: got %b/%b want 1/0", mif.mem_req, mif.mem_we);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (obs() !== 11'b0 || {OpCode, XO} !== 15'b0) begin
            n_fail++;
            $display("FAIL rst_mid outputs: got %b op %0d xo %0d want all 0", obs(), OpCode, XO);
        end
        n_chk++;
        if (state_o !== 4'(S_IDLE)) begin
            n_fail++;
            $display("FAIL rst_mid state: got %0d want %0d", state_o, 4'(S_IDLE));
        end
        @(negedge clk);
        rst  = 1'b0;
        m_ir = '0;
        idle('0);
        instr(W_BC, 0, 0);
        run_q("rst_mid_post");
    endtask

`ifdef UPOWER_ILLEGAL_TRAP_EN
    task automatic test_trap();
        instr(32'h0000_0000, 0, 0);
        for (int i = 0; i < 6; i++) idle('0);
        run_q("trap");
        test_reset();
        instr(W_ADD, 0, 0);
        run_q("trap_recover");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_random();
        test_reset_mid_access();
`ifdef UPOWER_ILLEGAL_TRAP_EN
        test_trap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
